// File: rtl/z_tile_buffer.sv
// Tile depth buffer: one Z word per tile pixel, 2-stage read/compare/write
// pipeline with same-address forwarding, plus a programmable clear sweep.
module z_tile_buffer #(
  parameter int unsigned Z_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear_z,
  input  logic [Z_WIDTH-1:0]    clear_val,
  output logic                  clear_busy,
  output logic                  clear_done,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic [ADDR_WIDTH-1:0] pix_addr,
  input  logic [Z_WIDTH-1:0]    pix_z,
  input  logic [2:0]            depth_comp,
  input  logic                  z_write_disable,
  output logic                  out_valid,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [Z_WIDTH-1:0]    old_z,
  output logic                  depth_allow
);

  localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
  localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_BUSY} state_t;

  state_t               state, state_next;
  logic [CNT_WIDTH-1:0] cnt, cnt_next;
  logic [Z_WIDTH-1:0]   fill_val;
  logic                 fill_capture;
  logic                 done_next;
  logic                 accept;

  logic                  s1_valid;
  logic [ADDR_WIDTH-1:0] s1_addr;
  logic [Z_WIDTH-1:0]    s1_z;
  logic [2:0]            s1_comp;
  logic                  s1_wd;
  logic                  s1_fwd;
  logic [Z_WIDTH-1:0]    s1_fwd_data;
  logic [Z_WIDTH-1:0]    s1_old;
  logic                  s1_pass;

  logic [Z_WIDTH-1:0]    s2_z;
  logic                  s2_wd;

  logic [Z_WIDTH-1:0]    mem [DEPTH];
  logic [Z_WIDTH-1:0]    ram_q;
  logic                  pix_we;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [Z_WIDTH-1:0]    ram_wdata;

  assign pix_ready  = (state == ST_IDLE);
  assign clear_busy = (state == ST_BUSY);
  assign accept     = pix_valid && pix_ready;
  assign pix_we     = out_valid && depth_allow && !s2_wd;

  // Clear sequencer: pend until the pipeline drains, then sweep every address once
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    fill_capture = 1'b0;
    done_next    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (clear_z) begin
          state_next   = ST_PEND;
          fill_capture = 1'b1;
        end
      end
      ST_PEND: begin
        if (!s1_valid && !out_valid) begin
          state_next = ST_BUSY;
          cnt_next   = '0;
        end
      end
      ST_BUSY: begin
        cnt_next = cnt + CNT_WIDTH'(1);
        if (cnt == CNT_WIDTH'(DEPTH - 1)) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      fill_val   <= '0;
      clear_done <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      clear_done <= done_next;
      if (fill_capture) fill_val <= clear_val;
    end
  end

  // A committing S2 write overrides the RAM data S1 read one cycle too early
  always_comb begin
    s1_old = s1_fwd ? s1_fwd_data : ram_q;
    if (pix_we && (out_addr == s1_addr)) s1_old = s2_z;
  end

  // depth_comp is a mask over {greater, equal, less}
  always_comb begin
    s1_pass = 1'b0;
    if (s1_z < s1_old)       s1_pass = s1_comp[0];
    else if (s1_z == s1_old) s1_pass = s1_comp[1];
    else                     s1_pass = s1_comp[2];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid    <= 1'b0;
      s1_addr     <= '0;
      s1_z        <= '0;
      s1_comp     <= '0;
      s1_wd       <= 1'b0;
      s1_fwd      <= 1'b0;
      s1_fwd_data <= '0;
      out_valid   <= 1'b0;
      out_addr    <= '0;
      old_z       <= '0;
      depth_allow <= 1'b0;
      s2_z        <= '0;
      s2_wd       <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_addr     <= pix_addr;
        s1_z        <= pix_z;
        s1_comp     <= depth_comp;
        s1_wd       <= z_write_disable;
        s1_fwd      <= pix_we && (out_addr == pix_addr);
        s1_fwd_data <= s2_z;
      end
      out_valid   <= s1_valid;
      depth_allow <= s1_valid && s1_pass;
      if (s1_valid) begin
        out_addr <= s1_addr;
        old_z    <= s1_old;
        s2_z     <= s1_z;
        s2_wd    <= s1_wd;
      end
    end
  end

  // Single write port shared by the sweep and pixel commits (never concurrent)
  assign ram_we    = clear_busy || pix_we;
  assign ram_waddr = clear_busy ? cnt[ADDR_WIDTH-1:0] : out_addr;
  assign ram_wdata = clear_busy ? fill_val : s2_z;

  always_ff @(posedge clock) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    ram_q <= mem[pix_addr];
  end

endmodule
